pay_station: RTL
================

# pay_station

Pay-station controller at the exit side of the car park: issues the `Pay` pulse the barrier controller consumes before opening the exit bar. It timestamps nothing itself. It receives the entry timestamp from a presented ticket, computes the parking fee from an internal time base, and collects coins. It then asserts a single-cycle pay strobe and returns change, or refunds on cancel or timeout.

## Interface
- `TW`, 8: width of the time-unit counter and of ticket timestamps.
- `TICK_DIV`, 1000: clk cycles per time unit; must be ≥2.
- `CW`, 12: width of cost, credit, due and change.
- `RATE`, 3: cost per elapsed time unit.
- `MAX_COST`, 60: fee cap; must be < 2^CW.
- `TIMEOUT`, 30000: clk cycles allowed in COLLECT without a coin before an automatic refund.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `ticket_valid` in 1: one-cycle strobe; ticket presented.
- `ticket_time` in TW: entry time unit printed on the ticket.
- `coin_valid` in 1: one-cycle strobe; coin inserted.
- `coin_value` in 5: face value of the inserted coin.
- `cancel` in 1: user abort.
- `change_ack` in 1: dispenser has taken `change`.
- `now` out TW: current time unit, used by the entry side to print tickets.
- `ready` out 1: high in IDLE only.
- `due` out CW: remaining amount to pay.
- `pay` out 1: one-cycle strobe; fee fully paid. Drives the barrier controller's `Pay`.
- `coin_reject` out 1: one-cycle strobe; coin value not accepted.
- `change` out CW: amount to dispense.
- `change_valid` out 1: `change` is valid; held until `change_ack`.

## Operation
- Time base: a prescaler counts 0..TICK_DIV-1. On its terminal count, `now` increments modulo 2^TW. The time base runs in every state.
- States: IDLE, CALC, COLLECT, PAID, CHANGE, REFUND.
- IDLE: `ready`=1, `due`=0. `ticket_valid` latches `ticket_time` and moves to CALC. `coin_valid`, `cancel` and `change_ack` are ignored.
- CALC (one cycle):
  - elapsed = (now − ticket_time) mod 2^TW; wrap-around is legal.
  - units = max(elapsed, 1).
  - cost = min(units·RATE, MAX_COST). The product is computed in TW+CW bits, then saturated.
  - Credit is cleared; go to COLLECT.
- COLLECT:
  - `due` = cost − credit.
  - Accepted coin values are 1, 2, 5, 10 and 20. Any other value pulses `coin_reject` next cycle and leaves credit unchanged.
  - An accepted coin adds to credit, saturating at 2^CW−1, and restarts the timeout counter.
  - credit ≥ cost → PAID.
  - `cancel`, or TIMEOUT cycles without a coin → REFUND.
- Simultaneous coin + cancel: the coin is credited first. If the coin completes payment, PAID wins. Otherwise go to REFUND, and the refund includes that coin.
- PAID (one cycle): `pay`=1, `due`=0, `change` = credit − cost. Go to CHANGE if change > 0, else IDLE.
- CHANGE / REFUND: `change_valid`=1 with `change` stable (change = credit − cost in CHANGE, change = credit in REFUND). Stay until `change_ack`, then go to IDLE. REFUND with credit = 0 goes straight to IDLE without asserting `change_valid`. `pay` never asserts on the REFUND path.
- `ticket_valid` outside IDLE is ignored.

## Timing
- Reset (rst low, asynchronous):
  - state = IDLE; `now`, prescaler, credit and timeout counter cleared.
  - Outputs: `ready`=1, `due`=0, `pay`=0, `coin_reject`=0, `change`=0, `change_valid`=0.
- Reset mid-transaction discards credit; no `pay` and no refund are issued.
- All outputs are registered or decoded from registered state; no input-to-output combinational paths.
- Ticket latency: `ticket_valid` sampled at edge N → CALC after N; COLLECT with `due` valid after edge N+1.
- Pay latency: the completing coin is sampled at edge M → `pay` high for exactly the cycle after edge M+1. IDLE (or CHANGE) follows after edge M+2.
- `coin_reject` asserts for the cycle after the rejected coin's sampling edge.
- `change_ack` is sampled only while `change_valid`=1. State is IDLE on the next edge.

## Structure
- Shared package `parking_pkg`:
  - state encoding constants;
  - accepted coin values;
  - shared with the barrier controller's definitions.
- Sub-module `park_timebase`:
  - contains the prescaler and the `now` counter;
  - parameters TICK_DIV and TW;
  - reusable by the entry side for ticket printing.

## Test plan
Parameters for all scenarios: TW=8, TICK_DIV=4, RATE=3, MAX_COST=60, TIMEOUT=20.
- Exact payment: ticket_time = now−4 → `due`=12 in COLLECT. Coins 10 then 2 → `pay` high for one cycle only; `change_valid` never asserts; `ready` returns to 1.
- Overpay: `due`=12, coins 10 then 5 → `pay` pulse, then `change`=3 with `change_valid` held until `change_ack`, then IDLE.
- Wrap and caps:
  - now=2, ticket_time=254 → cost 12;
  - elapsed 0 → cost 3;
  - elapsed 30 → cost 60.
- Cancel and reject:
  - coin 3 → `coin_reject` pulse, `due` unchanged;
  - coin 5 then `cancel` → no `pay`, `change`=5 refunded;
  - coin 2 plus `cancel` in the same cycle with `due`=12 → refund 2.
- Timeout:
  - coin 1, then 20 idle cycles → REFUND with `change`=1;
  - no coins, 20 idle cycles → direct return to IDLE with no `change_valid`.
- Async reset: `rst` low mid-COLLECT with credit 5 → immediately IDLE, `ready`=1, `due`=0, no `pay`, no `change_valid`, `now`=0.

Source files
------------

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared car-park definitions: controller states and coin set
// Contents:
//   pay_state_t   : pay-station controller state encoding
//   COIN_W        : width of a coin face value
//   COIN_*        : accepted coin face values
//   coin_accepted : returns 1 when a coin face value is accepted
package parking_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CALC    = 3'd1,
        ST_COLLECT = 3'd2,
        ST_PAID    = 3'd3,
        ST_CHANGE  = 3'd4,
        ST_REFUND  = 3'd5
    } pay_state_t;

    localparam int COIN_W = 5;

    localparam logic [COIN_W-1:0] COIN_1  = 5'd1;
    localparam logic [COIN_W-1:0] COIN_2  = 5'd2;
    localparam logic [COIN_W-1:0] COIN_5  = 5'd5;
    localparam logic [COIN_W-1:0] COIN_10 = 5'd10;
    localparam logic [COIN_W-1:0] COIN_20 = 5'd20;

    function automatic logic coin_accepted(input logic [COIN_W-1:0] value);
        case (value)
            COIN_1, COIN_2, COIN_5, COIN_10, COIN_20: coin_accepted = 1'b1;
            default:                                  coin_accepted = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pay_station_if.sv
// rtl/pay_station_if.sv - pay-station user/dispenser signal bundle
// Parameters: TW (time-unit width), CW (money width)
// Signals driven by the user side (master): ticket_valid, ticket_time,
//   coin_valid, coin_value, cancel, change_ack
// Signals driven by the pay station (slave): now, ready, due, pay,
//   coin_reject, change, change_valid
interface pay_station_if #(
    parameter int TW = 8,
    parameter int CW = 12
);
    logic          ticket_valid;
    logic [TW-1:0] ticket_time;
    logic          coin_valid;
    logic [4:0]    coin_value;
    logic          cancel;
    logic          change_ack;
    logic [TW-1:0] now;
    logic          ready;
    logic [CW-1:0] due;
    logic          pay;
    logic          coin_reject;
    logic [CW-1:0] change;
    logic          change_valid;

    modport master (
        output ticket_valid, ticket_time, coin_valid, coin_value, cancel, change_ack,
        input  now, ready, due, pay, coin_reject, change, change_valid
    );

    modport slave (
        input  ticket_valid, ticket_time, coin_valid, coin_value, cancel, change_ack,
        output now, ready, due, pay, coin_reject, change, change_valid
    );
endinterface

// File: rtl/park_timebase.sv
// rtl/park_timebase.sv - car-park time base: prescaler plus wrapping time-unit counter
// Parameters: TICK_DIV (clk cycles per time unit, >= 2), TW (time-unit width)
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   now : current time unit, increments modulo 2^TW every TICK_DIV cycles
module park_timebase #(
    parameter int TICK_DIV = 1000,
    parameter int TW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    output logic [TW-1:0] now
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc <= '0;
            now   <= '0;
        end else if (tick) begin
            presc <= '0;
            now   <= now + TW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/pay_station.sv
// rtl/pay_station.sv - exit-side pay-station: fee calculation, coin collection, pay strobe, change/refund
// Parameters: TW, TICK_DIV, CW, RATE, MAX_COST, TIMEOUT
// Ports:
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : pay_station_if.slave - ticket and coin inputs, cancel, change handshake,
//         now/ready/due/pay/coin_reject/change/change_valid outputs
module pay_station
    import parking_pkg::*;
#(
    parameter int TW       = 8,
    parameter int TICK_DIV = 1000,
    parameter int CW       = 12,
    parameter int RATE     = 3,
    parameter int MAX_COST = 60,
    parameter int TIMEOUT  = 30000
) (
    input  logic         clk,
    input  logic         rst,
    pay_station_if.slave bus
);

    localparam int TOW = $clog2(TIMEOUT + 1);

    pay_state_t     state, state_n;
    logic [TW-1:0]  now_q;
    logic [TW-1:0]  ticket_q, ticket_n;
    logic [CW-1:0]  cost, cost_n;
    logic [CW-1:0]  credit, credit_n;
    logic [TOW-1:0] tcnt, tcnt_n;
    logic           reject_q, reject_n;

    logic [TW-1:0]    elapsed;
    logic [TW-1:0]    units;
    logic [TW+CW-1:0] product;
    logic [CW-1:0]    cost_calc;
    logic             coin_ok;
    logic [CW:0]      credit_sum;
    logic [CW-1:0]    credit_add;
    logic [CW-1:0]    credit_after;

    park_timebase #(
        .TICK_DIV (TICK_DIV),
        .TW       (TW)
    ) u_timebase (
        .clk (clk),
        .rst (rst),
        .now (now_q)
    );

    assign bus.now = now_q;

    // Fee: modular elapsed time, at least one unit, product widened then capped.
    assign elapsed   = now_q - ticket_q;
    assign units     = (elapsed == '0) ? TW'(1) : elapsed;
    assign product   = (TW+CW)'(units) * (TW+CW)'(RATE);
    assign cost_calc = (product > (TW+CW)'(MAX_COST)) ? CW'(MAX_COST) : product[CW-1:0];

    // Credit including this cycle's coin, saturating at the top of the money range.
    assign coin_ok      = bus.coin_valid && coin_accepted(bus.coin_value);
    assign credit_sum   = {1'b0, credit} + (CW+1)'(bus.coin_value);
    assign credit_add   = credit_sum[CW] ? '1 : credit_sum[CW-1:0];
    assign credit_after = coin_ok ? credit_add : credit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            ticket_q <= '0;
            cost     <= '0;
            credit   <= '0;
            tcnt     <= '0;
            reject_q <= 1'b0;
        end else begin
            state    <= state_n;
            ticket_q <= ticket_n;
            cost     <= cost_n;
            credit   <= credit_n;
            tcnt     <= tcnt_n;
            reject_q <= reject_n;
        end
    end

    always_comb begin
        state_n          = state;
        ticket_n         = ticket_q;
        cost_n           = cost;
        credit_n         = credit;
        tcnt_n           = tcnt;
        reject_n         = 1'b0;
        bus.ready        = 1'b0;
        bus.due          = '0;
        bus.pay          = 1'b0;
        bus.change       = '0;
        bus.change_valid = 1'b0;
        bus.coin_reject  = reject_q;

        case (state)
            ST_IDLE: begin
                bus.ready = 1'b1;
                if (bus.ticket_valid) begin
                    ticket_n = bus.ticket_time;
                    state_n  = ST_CALC;
                end
            end

            ST_CALC: begin
                cost_n   = cost_calc;
                credit_n = '0;
                tcnt_n   = '0;
                state_n  = ST_COLLECT;
            end

            ST_COLLECT: begin
                if (credit < cost) begin
                    bus.due = cost - credit;
                end
                reject_n = bus.coin_valid && !coin_accepted(bus.coin_value);
                credit_n = credit_after;
                tcnt_n   = coin_ok ? '0 : tcnt + TOW'(1);
                // A coin that completes payment wins over a simultaneous cancel:
                // stay here one more cycle so PAID follows from the registered credit.
                if (credit >= cost) begin
                    state_n = ST_PAID;
                end else if (credit_after >= cost) begin
                    state_n = ST_COLLECT;
                end else if (bus.cancel) begin
                    state_n = ST_REFUND;
                end else if (!coin_ok && tcnt == TOW'(TIMEOUT - 1)) begin
                    state_n = ST_REFUND;
                end
            end

            ST_PAID: begin
                bus.pay    = 1'b1;
                bus.change = credit - cost;
                state_n    = (credit != cost) ? ST_CHANGE : ST_IDLE;
            end

            ST_CHANGE: begin
                bus.change       = credit - cost;
                bus.change_valid = 1'b1;
                if (bus.change_ack) begin
                    state_n = ST_IDLE;
                end
            end

            ST_REFUND: begin
                bus.change = credit;
                if (credit == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    bus.change_valid = 1'b1;
                    if (bus.change_ack) begin
                        state_n = ST_IDLE;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule
